// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the main-RAM arbiter between the 6502 core
// and the secondary (SD/video DMA) bus master.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DMA  = 2'd2
  } owner_e;

  localparam int WAIT_CNT_W       = 4;
  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 8;
  localparam int DMA_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter: counts consecutive cycles a pending DMA
// request loses to the CPU, and flags when the forced-slot limit is reached.
module arb_starve_cnt
  import ram_arb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req,
  input  logic                  lose,
  input  logic                  win,
  input  logic [WAIT_CNT_W-1:0] limit,
  output logic                  at_limit,
  output logic [WAIT_CNT_W-1:0] count
);

  // Clear when the request goes away or is served, otherwise count losses up to the limit
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (!req || win) begin
      count <= '0;
    end else if (lose && (count < limit)) begin
      count <= count + WAIT_CNT_W'(1);
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/ram_arbiter.sv
// Main-RAM arbiter: fixed CPU priority with a starvation limiter that forces
// a DMA slot and stalls the CPU through RDY.
// Optional feature macro: ARB_PERF_CNT_EN (DMA grant and CPU stall counters).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DMA_MAX_WAIT = DMA_MAX_WAIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rdy_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic              perf_clr_i,
  output logic [15:0]       perf_dma_cnt_o,
  output logic [15:0]       perf_stall_cnt_o
`endif
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(DMA_MAX_WAIT);

  owner_e                owner;
  owner_e                owner_q;
  logic                  rd_q;
  logic                  at_limit;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [DATA_W-1:0]     cpu_hold_q;
  logic [DATA_W-1:0]     dma_hold_q;
  logic                  cpu_ret;

  arb_starve_cnt u_starve (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req      (dma_req_i),
    .lose     (dma_req_i && (owner == S_CPU)),
    .win      (owner == S_DMA),
    .limit    (LIMIT),
    .at_limit (at_limit),
    .count    (wait_cnt)
  );

  // Pick this cycle's owner and steer its request onto the RAM port
  always_comb begin
    owner       = S_IDLE;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (dma_req_i && (!cpu_req_i || at_limit)) begin
      owner       = S_DMA;
      ram_en_o    = 1'b1;
      ram_we_o    = dma_we_i;
      ram_addr_o  = dma_addr_i;
      ram_wdata_o = dma_wdata_i;
    end else if (cpu_req_i) begin
      owner       = S_CPU;
      ram_en_o    = 1'b1;
      ram_we_o    = cpu_we_i;
      ram_addr_o  = cpu_addr_i;
      ram_wdata_o = cpu_wdata_i;
    end
  end

  assign dma_gnt_o = (owner == S_DMA);
  assign cpu_rdy_o = !(cpu_req_i && (owner == S_DMA));

  // Remember who owned the RAM and whether it was a read, for routing the return data
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q <= S_IDLE;
      rd_q    <= 1'b0;
    end else begin
      owner_q <= owner;
      rd_q    <= (owner != S_IDLE) && !ram_we_o;
    end
  end

  assign cpu_ret      = rd_q && (owner_q == S_CPU);
  assign dma_rvalid_o = rd_q && (owner_q == S_DMA);
  assign cpu_rdata_o  = cpu_ret ? ram_rdata_i : cpu_hold_q;
  assign dma_rdata_o  = dma_rvalid_o ? ram_rdata_i : dma_hold_q;

  // Hold the last returned read value for each master between returns
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cpu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      if (cpu_ret)      cpu_hold_q <= ram_rdata_i;
      if (dma_rvalid_o) dma_hold_q <= ram_rdata_i;
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Count DMA grants and CPU stall cycles; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_dma_cnt_o   <= '0;
      perf_stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      perf_dma_cnt_o   <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (dma_gnt_o)  perf_dma_cnt_o   <= perf_dma_cnt_o + 16'd1;
      if (!cpu_rdy_o) perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 1-cycle RAM.
module tb_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cpu_req_i, cpu_we_i;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_wdata_i, cpu_rdata_o;
  logic        cpu_rdy_o;
  logic        dma_req_i, dma_we_i;
  logic [15:0] dma_addr_i;
  logic [7:0]  dma_wdata_i, dma_rdata_o;
  logic        dma_gnt_o, dma_rvalid_o;
  logic        ram_en_o, ram_we_o;
  logic [15:0] ram_addr_o;
  logic [7:0]  ram_wdata_o, ram_rdata_i;
`ifdef ARB_PERF_CNT_EN
  logic        perf_clr_i;
  logic [15:0] perf_dma_cnt_o, perf_stall_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:65535];

  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .DMA_MAX_WAIT(4)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_rdy_o    (cpu_rdy_o),
    .dma_req_i    (dma_req_i),
    .dma_we_i     (dma_we_i),
    .dma_addr_i   (dma_addr_i),
    .dma_wdata_i  (dma_wdata_i),
    .dma_gnt_o    (dma_gnt_o),
    .dma_rvalid_o (dma_rvalid_o),
    .dma_rdata_o  (dma_rdata_o),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_clr_i       (perf_clr_i),
    .perf_dma_cnt_o   (perf_dma_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port synchronous RAM with one cycle of read latency
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      ram_rdata_i <= mem[ram_addr_o];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic creq, input logic cwe, input logic [15:0] caddr,
                               input logic dreq, input logic dwe, input logic [15:0] daddr,
                               input logic [7:0] dwdata);
    cpu_req_i   = creq;
    cpu_we_i    = cwe;
    cpu_addr_i  = caddr;
    cpu_wdata_i = 8'h00;
    dma_req_i   = dreq;
    dma_we_i    = dwe;
    dma_addr_i  = daddr;
    dma_wdata_i = dwdata;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    mem[16'h1234] = 8'hAA;
    mem[16'h1235] = 8'hBB;
    mem[16'h0100] = 8'h77;
    ram_rdata_i   = 8'h00;
    rst_n_i       = 1'b0;
`ifdef ARB_PERF_CNT_EN
    perf_clr_i    = 1'b0;
`endif
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
    step();
    step();
    checkOutput("rst_rvalid", dma_rvalid_o, 0);
    checkOutput("rst_cpu_rdata", cpu_rdata_o, 8'h00);
    checkOutput("rst_dma_rdata", dma_rdata_o, 8'h00);
    checkOutput("rst_ram_en", ram_en_o, 0);
    checkOutput("rst_rdy", cpu_rdy_o, 1);
    rst_n_i = 1'b1;
    step();

    // CPU-only reads
    applyStimulus(1, 0, 16'h1234, 0, 0, 16'h0, 8'h00);
    checkOutput("cpu_rd0_rdy", cpu_rdy_o, 1);
    checkOutput("cpu_rd0_addr", ram_addr_o, 16'h1234);
    step();
    applyStimulus(1, 0, 16'h1235, 0, 0, 16'h0, 8'h00);
    checkOutput("cpu_rd0_data", cpu_rdata_o, 8'hAA);
    checkOutput("cpu_rd1_rdy", cpu_rdy_o, 1);
    step();
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
    checkOutput("cpu_rd1_data", cpu_rdata_o, 8'hBB);
    step();
    checkOutput("cpu_rdata_hold", cpu_rdata_o, 8'hBB);

    // DMA-only write then read back
    applyStimulus(0, 0, 16'h0, 1, 1, 16'h2000, 8'h55);
    checkOutput("dma_wr_gnt", dma_gnt_o, 1);
    checkOutput("dma_wr_we", ram_we_o, 1);
    step();
    applyStimulus(0, 0, 16'h0, 1, 0, 16'h2000, 8'h00);
    checkOutput("dma_rd_gnt", dma_gnt_o, 1);
    checkOutput("dma_wr_no_rvalid", dma_rvalid_o, 0);
    step();
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
    checkOutput("dma_rd_rvalid", dma_rvalid_o, 1);
    checkOutput("dma_rd_data", dma_rdata_o, 8'h55);
    checkOutput("dma_idle_gnt", dma_gnt_o, 0);
    step();
    checkOutput("dma_rvalid_pulse", dma_rvalid_o, 0);
    checkOutput("dma_rdata_hold", dma_rdata_o, 8'h55);

    // Starvation limiter: forced DMA every fifth cycle
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 0, 16'h0100, 1, 0, 16'h2000, 8'h00);
      checkOutput($sformatf("starve_gnt%0d", k), dma_gnt_o, (k % 5) == 4);
      checkOutput($sformatf("starve_rdy%0d", k), cpu_rdy_o, (k % 5) != 4);
      if (k > 0)
        checkOutput($sformatf("starve_rvalid%0d", k), dma_rvalid_o, (k % 5) == 0);
      step();
    end
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
    step();

    // Simultaneous request with wait counter at zero
    applyStimulus(1, 0, 16'h0100, 1, 0, 16'h2000, 8'h00);
    checkOutput("sim_gnt", dma_gnt_o, 0);
    checkOutput("sim_rdy", cpu_rdy_o, 1);
    checkOutput("sim_addr", ram_addr_o, 16'h0100);
    step();
    checkOutput("sim_wait_cnt", dut.wait_cnt, 1);
    checkOutput("sim_cpu_rdata", cpu_rdata_o, 8'h77);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
    checkOutput("drop_wait_cnt_pre", dut.wait_cnt, 1);
    step();
    checkOutput("drop_wait_cnt", dut.wait_cnt, 0);

    // DMA read granted, then async reset before the return
    applyStimulus(0, 0, 16'h0, 1, 0, 16'h2000, 8'h00);
    checkOutput("rstrd_gnt", dma_gnt_o, 1);
    step();
    rst_n_i = 1'b0;
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
    checkOutput("rstrd_rvalid", dma_rvalid_o, 0);
    checkOutput("rstrd_dma_rdata", dma_rdata_o, 8'h00);
    checkOutput("rstrd_cpu_rdata", cpu_rdata_o, 8'h00);
    checkOutput("rstrd_wait_cnt", dut.wait_cnt, 0);
    checkOutput("rstrd_ram_en", ram_en_o, 0);
    step();
    rst_n_i = 1'b1;
    step();

`ifdef ARB_PERF_CNT_EN
    // Performance counters over four starvation periods, then clear
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 0, 16'h0100, 1, 0, 16'h2000, 8'h00);
      step();
    end
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
    checkOutput("perf_dma", perf_dma_cnt_o, 16'd4);
    checkOutput("perf_stall", perf_stall_cnt_o, 16'd4);
    perf_clr_i = 1'b1;
    step();
    perf_clr_i = 1'b0;
    checkOutput("perf_dma_clr", perf_dma_cnt_o, 16'd0);
    checkOutput("perf_stall_clr", perf_stall_cnt_o, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
